// File: rtl/game2048_pkg.sv
// ============================================================================
//  Module   : game2048_pkg
//  Purpose  : Types and constants shared by the 2048 board datapath blocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package game2048_pkg;
  localparam int TILE_W   = 12;
  localparam int BOARD_N  = 4;
  localparam int MAX_TILE = 2048;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;
endpackage

`default_nettype wire

// File: rtl/line_merge.sv
// ============================================================================
//  Module   : line_merge
//  Purpose  : Combinational slide-and-merge of one 4-tile line toward index 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_merge #(
  parameter int TILE_W   = 12,
  parameter int SCORE_W  = 16,
  parameter int MAX_TILE = 2048
) (
  input  logic [3:0][TILE_W-1:0] line_in,
  output logic [3:0][TILE_W-1:0] line_out,
  output logic [SCORE_W-1:0]     line_score,
  output logic                   line_changed
);

  // One spare zero slot at the back keeps the pair compare in range for k=3.
  logic [4:0][TILE_W-1:0] w_packed;
  logic [2:0]             w_fill;
  logic [2:0]             w_wr;
  logic                   w_skip;

  always_comb begin
    w_packed = '0;
    w_fill   = '0;
    for (int k = 0; k < 4; k++) begin
      if (line_in[k] != '0) begin
        w_packed[w_fill] = line_in[k];
        w_fill           = w_fill + 3'd1;
      end
    end
  end

  always_comb begin
    line_out   = '0;
    line_score = '0;
    w_wr       = '0;
    w_skip     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_packed[k] != '0 && w_packed[k] == w_packed[k+1] &&
                   w_packed[k] < TILE_W'(MAX_TILE)) begin
        line_out[w_wr[1:0]] = w_packed[k] << 1;
        line_score          = line_score + SCORE_W'(w_packed[k] << 1);
        w_wr                = w_wr + 3'd1;
        w_skip              = 1'b1;
      end else if (w_packed[k] != '0) begin
        line_out[w_wr[1:0]] = w_packed[k];
        w_wr                = w_wr + 3'd1;
      end
    end
  end

  assign line_changed = (line_out != line_in);

endmodule

`default_nettype wire

// File: rtl/board_move_engine.sv
// ============================================================================
//  Module   : board_move_engine
//  Purpose  : Applies one 2048 move to a 4x4 board, one line per clock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_move_engine #(
  parameter int TILE_W   = 12,
  parameter int SCORE_W  = 16,
  parameter int MAX_TILE = 2048
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  dir,
  input  logic [3:0][3:0][TILE_W-1:0] board_in,
  output logic [3:0][3:0][TILE_W-1:0] board_out,
  output logic                        busy,
  output logic                        done,
  output logic                        moved,
  output logic [SCORE_W-1:0]          score_add
);
  import game2048_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        w_start_move;
  logic [1:0]                  r_idx;
  dir_e                        r_dir;
  logic [3:0][3:0][TILE_W-1:0] r_board;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_moved;
  logic [SCORE_W-1:0]          r_score;

  logic [3:0][TILE_W-1:0]      w_line_in;
  logic [3:0][TILE_W-1:0]      w_line_out;
  logic [SCORE_W-1:0]          w_line_score;
  logic                        w_line_changed;
  logic [3:0][3:0][TILE_W-1:0] w_board_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_move = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_state_next = ST_PROC;
        w_start_move = 1'b1;
      end
      ST_PROC: if (r_idx == 2'd3) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Line index k=0 is always the cell nearest the wall the tiles move toward.
  always_comb begin
    w_line_in    = '0;
    w_board_next = r_board;
    for (int k = 0; k < BOARD_N; k++) begin
      case (r_dir)
        DIR_LEFT: begin
          w_line_in[k]             = r_board[r_idx][k];
          w_board_next[r_idx][k]   = w_line_out[k];
        end
        DIR_RIGHT: begin
          w_line_in[k]                       = r_board[r_idx][BOARD_N-1-k];
          w_board_next[r_idx][BOARD_N-1-k]   = w_line_out[k];
        end
        DIR_UP: begin
          w_line_in[k]             = r_board[k][r_idx];
          w_board_next[k][r_idx]   = w_line_out[k];
        end
        default: begin
          w_line_in[k]                       = r_board[BOARD_N-1-k][r_idx];
          w_board_next[BOARD_N-1-k][r_idx]   = w_line_out[k];
        end
      endcase
    end
  end

  line_merge #(
    .TILE_W   (TILE_W),
    .SCORE_W  (SCORE_W),
    .MAX_TILE (MAX_TILE)
  ) u_line_merge (
    .line_in      (w_line_in),
    .line_out     (w_line_out),
    .line_score   (w_line_score),
    .line_changed (w_line_changed)
  );

  // Each line is read once before it is rewritten, so per-line change flags
  // OR together into a whole-board compare against the captured input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_dir   <= DIR_LEFT;
      r_board <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_moved <= 1'b0;
      r_score <= '0;
    end else if (w_start_move) begin
      r_idx   <= '0;
      r_dir   <= dir_e'(dir);
      r_board <= board_in;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_moved <= 1'b0;
      r_score <= '0;
    end else if (r_state == ST_PROC) begin
      r_board <= w_board_next;
      r_score <= r_score + w_line_score;
      r_moved <= r_moved | w_line_changed;
      r_idx   <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign board_out = r_board;
  assign busy      = r_busy;
  assign done      = r_done;
  assign moved     = r_moved;
  assign score_add = r_score;

endmodule

`default_nettype wire

// File: tb/tb_board_move_engine.sv
// ============================================================================
//  Module   : tb_board_move_engine
//  Purpose  : Directed self-checking bench for board_move_engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_move_engine;

  typedef logic [3:0][3:0][11:0] brd_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  dir;
  brd_t        board_in;
  brd_t        board_out;
  logic        busy;
  logic        done;
  logic        moved;
  logic [15:0] score_add;

  int checks;
  int errors;

  board_move_engine u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .board_in  (board_in),
    .board_out (board_out),
    .busy      (busy),
    .done      (done),
    .moved     (moved),
    .score_add (score_add)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0][11:0] row4(input int a, input int b, input int c, input int d);
    logic [3:0][11:0] r;
    r[0] = 12'(a);
    r[1] = 12'(b);
    r[2] = 12'(c);
    r[3] = 12'(d);
    return r;
  endfunction

  // Leaves an idle gap, issues one start, returns edges until done (0 = timeout).
  task automatic run_move(input brd_t b, input logic [1:0] d, output int lat);
    @(negedge clk);
    @(negedge clk);
    board_in = b;
    dir      = d;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || moved !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b moved=%b want 0 0 0", busy, done, moved);
    end
    checks++;
    if (score_add !== 16'd0 || board_out !== '0) begin
      errors++;
      $display("FAIL reset_data score=%0d board=%h want 0", score_add, board_out);
    end
  endtask

  task automatic test_left_merge_all();
    brd_t b, e;
    int   lat;
    b = '0; b[0] = row4(2, 2, 2, 2);
    e = '0; e[0] = row4(4, 4, 0, 0);
    run_move(b, 2'd0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL left2222_latency got %0d want 4", lat);
    end
    checks++;
    if (board_out !== e) begin
      errors++;
      $display("FAIL left2222_board got %h want %h", board_out, e);
    end
    checks++;
    if (score_add !== 16'd8 || moved !== 1'b1) begin
      errors++;
      $display("FAIL left2222_score got score=%0d moved=%b want 8 1", score_add, moved);
    end
  endtask

  task automatic test_no_chain();
    brd_t b, e;
    int   lat;
    b = '0; b[0] = row4(2, 2, 4, 0);
    e = '0; e[0] = row4(4, 4, 0, 0);
    run_move(b, 2'd0, lat);
    checks++;
    if (board_out !== e || score_add !== 16'd4 || moved !== 1'b1) begin
      errors++;
      $display("FAIL no_chain got %h score=%0d moved=%b want %h 4 1", board_out, score_add, moved, e);
    end
  endtask

  task automatic test_right_up();
    brd_t b, e;
    int   lat;
    b = '0; b[1] = row4(4, 0, 0, 4);
    e = '0; e[1] = row4(0, 0, 0, 8);
    run_move(b, 2'd1, lat);
    checks++;
    if (board_out !== e || score_add !== 16'd8 || moved !== 1'b1) begin
      errors++;
      $display("FAIL right got %h score=%0d moved=%b want %h 8 1", board_out, score_add, moved, e);
    end
    b = '0;
    b[0][2] = 12'd2; b[1][2] = 12'd0; b[2][2] = 12'd2; b[3][2] = 12'd8;
    e = '0;
    e[0][2] = 12'd4; e[1][2] = 12'd8;
    run_move(b, 2'd2, lat);
    checks++;
    if (board_out !== e || score_add !== 16'd4 || moved !== 1'b1) begin
      errors++;
      $display("FAIL up got %h score=%0d moved=%b want %h 4 1", board_out, score_add, moved, e);
    end
  endtask

  task automatic test_down();
    brd_t b, e;
    int   lat;
    b = '0;
    b[0][1] = 12'd2; b[1][1] = 12'd2; b[2][1] = 12'd0; b[3][1] = 12'd4;
    e = '0;
    e[3][1] = 12'd4; e[2][1] = 12'd4;
    run_move(b, 2'd3, lat);
    checks++;
    if (board_out !== e || score_add !== 16'd4 || moved !== 1'b1) begin
      errors++;
      $display("FAIL down got %h score=%0d moved=%b want %h 4 1", board_out, score_add, moved, e);
    end
  endtask

  task automatic test_locked();
    brd_t b;
    int   lat;
    b[0] = row4(4, 16, 8, 2);
    b[1] = row4(8, 128, 64, 4);
    b[2] = row4(4, 32, 8, 16);
    b[3] = row4(2, 4, 16, 8);
    for (int d = 0; d < 4; d++) begin
      run_move(b, 2'(d), lat);
      checks++;
      if (board_out !== b || moved !== 1'b0 || score_add !== 16'd0) begin
        errors++;
        $display("FAIL locked_dir%0d got %h moved=%b score=%0d want %h 0 0", d, board_out, moved, score_add, b);
      end
    end
  endtask

  task automatic test_max_tile();
    brd_t b, e;
    int   lat;
    b = '0; b[0] = row4(2048, 2048, 1024, 1024);
    e = '0; e[0] = row4(2048, 2048, 2048, 0);
    run_move(b, 2'd0, lat);
    checks++;
    if (board_out !== e || score_add !== 16'd2048 || moved !== 1'b1) begin
      errors++;
      $display("FAIL max_tile got %h score=%0d moved=%b want %h 2048 1", board_out, score_add, moved, e);
    end
  endtask

  task automatic test_abort();
    brd_t b;
    b = '0; b[2] = row4(2, 2, 8, 8);
    @(negedge clk);
    @(negedge clk);
    board_in = b;
    dir      = 2'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got %b want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b board=%h want 0 0 0", busy, done, board_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_during_proc();
    brd_t a, b, e;
    int   lat;
    int   extra_done;
    a = '0; a[0] = row4(2, 2, 0, 0);
    b = '0; b[3] = row4(8, 8, 8, 8);
    e = '0; e[0] = row4(4, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    board_in = a;
    dir      = 2'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    board_in = b;
    dir      = 2'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 4 || board_out !== e || score_add !== 16'd4) begin
      errors++;
      $display("FAIL start_in_proc lat=%0d board=%h score=%0d want 4 %h 4", lat, board_out, score_add, e);
    end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || board_out !== e) begin
      errors++;
      $display("FAIL start_in_proc_queued activity=%0d board=%h want 0 %h", extra_done, board_out, e);
    end
  endtask

  task automatic test_back_to_back();
    brd_t a, b, e;
    int   lat;
    a = '0; a[1] = row4(0, 4, 0, 4);
    b = '0; b[2] = row4(16, 0, 16, 2);
    e = '0; e[2] = row4(0, 0, 32, 2);
    run_move(a, 2'd0, lat);
    @(negedge clk);
    board_in = b;
    dir      = 2'd1;
    start    = 1'b1;
    lat      = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL back_to_back_latency got %0d want 6", lat);
    end
    checks++;
    if (board_out !== e || score_add !== 16'd32 || moved !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_result got %h score=%0d moved=%b want %h 32 1", board_out, score_add, moved, e);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dir      = 2'd0;
    board_in = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_left_merge_all();
    test_no_chain();
    test_right_up();
    test_down();
    test_locked();
    test_max_tile();
    test_abort();
    test_reset();
    test_start_during_proc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
